// File: rtl/helppll_fdiff_mc_if.sv
// Bundle of measurement controls, synchronized helper Gray counters and the
// serial frequency-error result stream of helppll_fdiff_mc.
interface helppll_fdiff_mc_if #(
  parameter int NCH    = 2,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16,
  parameter int MWIDTH = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                    enable;
  logic [DWIDTH-1:0]       gate_len;
  logic [MWIDTH-1:0]       hmul;
  logic [MWIDTH-1:0]       rmul;
  logic [NCH*CWIDTH-1:0]   cnt_gray;
  logic [DWIDTH-1:0]       freqdiff;
  logic [CHW-1:0]          freqdiff_ch;
  logic                    stb_freqdiff;
  logic                    sat;
  logic                    busy;

  modport master (
    output enable, gate_len, hmul, rmul, cnt_gray,
    input  freqdiff, freqdiff_ch, stb_freqdiff, sat, busy
  );

  modport slave (
    input  enable, gate_len, hmul, rmul, cnt_gray,
    output freqdiff, freqdiff_ch, stb_freqdiff, sat, busy
  );
endinterface

// File: rtl/helppll_fdiff_mc.sv
// Multi-channel helper-PLL frequency comparator: gated Gray-counter sampling,
// per-channel scaled delta minus scaled gate, serial saturated error stream.
module helppll_fdiff_mc #(
  parameter int NCH    = 2,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16,
  parameter int MWIDTH = 4
) (
  input  logic               clk,
  input  logic               areset,
  helppll_fdiff_mc_if.slave  bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int HW  = CWIDTH + MWIDTH;
  localparam int RW  = DWIDTH + MWIDTH;
  localparam int XW  = DWIDTH + MWIDTH + 1;
  // Floor on the gate so a full burst (3 cycles per channel) ends before the next sample
  localparam logic [DWIDTH-1:0] GMIN    = DWIDTH'(3 * NCH + 2);
  localparam logic [DWIDTH-1:0] ONE     = DWIDTH'(1);
  localparam logic [CHW-1:0]    CH_LAST = CHW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELTA = 2'd1,
    SCALE = 2'd2,
    EMIT  = 2'd3
  } state_t;

  function automatic logic [CWIDTH-1:0] gray2bin(input logic [CWIDTH-1:0] g);
    logic [CWIDTH-1:0] b;
    b[CWIDTH-1] = g[CWIDTH-1];
    for (int i = CWIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [CHW-1:0]     ch_r, ch_nxt_s;
  logic               emit_s;
  logic [DWIDTH-1:0]  gcnt_r;
  logic [DWIDTH-1:0]  gate_lat_r;
  logic               valid_r;
  logic [DWIDTH-1:0]  g_eff_s;
  logic               samp_s;
  logic [CWIDTH-1:0]  cur_r  [NCH];
  logic [CWIDTH-1:0]  prev_r [NCH];
  logic [MWIDTH-1:0]  hm_lat_r, rm_lat_r;
  logic [CWIDTH-1:0]  d_r;
  logic [HW-1:0]      hp_r;
  logic [RW-1:0]      rp_r;
  logic [XW-1:0]      diff_s;
  logic               ovf_s;
  logic [DWIDTH-1:0]  clip_s;
  logic [DWIDTH-1:0]  freqdiff_r;
  logic [CHW-1:0]     freqdiff_ch_r;
  logic               stb_r;
  logic               sat_r;

  assign g_eff_s = (bus.gate_len < GMIN) ? GMIN : bus.gate_len;
  assign samp_s  = bus.enable && (gcnt_r == {DWIDTH{1'b0}});

  // Gate interval counter, gate length latch and first-sample qualifier
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      gcnt_r     <= {DWIDTH{1'b0}};
      gate_lat_r <= {DWIDTH{1'b0}};
      valid_r    <= 1'b0;
    end else if (!bus.enable) begin
      gcnt_r  <= g_eff_s - ONE;
      valid_r <= 1'b0;
    end else if (samp_s) begin
      gcnt_r     <= g_eff_s - ONE;
      gate_lat_r <= g_eff_s;
      valid_r    <= 1'b1;
    end else begin
      gcnt_r <= gcnt_r - ONE;
    end
  end

  // Snapshot of all channels and the multipliers used by the following burst
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < NCH; k++) begin
        cur_r[k]  <= {CWIDTH{1'b0}};
        prev_r[k] <= {CWIDTH{1'b0}};
      end
      hm_lat_r <= {MWIDTH{1'b0}};
      rm_lat_r <= {MWIDTH{1'b0}};
    end else if (samp_s) begin
      for (int k = 0; k < NCH; k++) begin
        cur_r[k]  <= gray2bin(bus.cnt_gray[k*CWIDTH +: CWIDTH]);
        prev_r[k] <= cur_r[k];
      end
      hm_lat_r <= bus.hmul;
      rm_lat_r <= bus.rmul;
    end
  end

  // Burst FSM state and channel index register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r <= IDLE;
      ch_r    <= {CHW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ch_r    <= ch_nxt_s;
    end
  end

  // Burst sequencing; dropping enable aborts without a further strobe
  always_comb begin
    state_nxt_s = state_r;
    ch_nxt_s    = ch_r;
    emit_s      = 1'b0;
    if (!bus.enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (samp_s && valid_r) begin
            state_nxt_s = DELTA;
            ch_nxt_s    = {CHW{1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end
        DELTA: state_nxt_s = SCALE;
        SCALE: state_nxt_s = EMIT;
        EMIT: begin
          emit_s = 1'b1;
          if (ch_r == CH_LAST) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DELTA;
            ch_nxt_s    = ch_r + CHW'(1);
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Difference is clipped when the bits above the signed DWIDTH range disagree
  assign diff_s = {{(XW-HW){1'b0}}, hp_r} - {{(XW-RW){1'b0}}, rp_r};
  assign ovf_s  = ~((&diff_s[XW-1:DWIDTH-1]) | ~(|diff_s[XW-1:DWIDTH-1]));
  assign clip_s = diff_s[XW-1] ? {1'b1, {(DWIDTH-1){1'b0}}}
                               : {1'b0, {(DWIDTH-1){1'b1}}};

  // Delta/scale pipeline and registered result stream
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      d_r           <= {CWIDTH{1'b0}};
      hp_r          <= {HW{1'b0}};
      rp_r          <= {RW{1'b0}};
      freqdiff_r    <= {DWIDTH{1'b0}};
      freqdiff_ch_r <= {CHW{1'b0}};
      stb_r         <= 1'b0;
      sat_r         <= 1'b0;
    end else begin
      stb_r <= 1'b0;
      if (state_r == DELTA) begin
        d_r <= cur_r[ch_r] - prev_r[ch_r];
      end
      if (state_r == SCALE) begin
        hp_r <= {{MWIDTH{1'b0}}, d_r} * {{CWIDTH{1'b0}}, hm_lat_r};
        rp_r <= {{MWIDTH{1'b0}}, gate_lat_r} * {{DWIDTH{1'b0}}, rm_lat_r};
      end
      if (emit_s) begin
        freqdiff_r    <= ovf_s ? clip_s : diff_s[DWIDTH-1:0];
        freqdiff_ch_r <= ch_r;
        sat_r         <= ovf_s;
        stb_r         <= 1'b1;
      end
    end
  end

  assign bus.freqdiff     = freqdiff_r;
  assign bus.freqdiff_ch  = freqdiff_ch_r;
  assign bus.stb_freqdiff = stb_r;
  assign bus.sat          = sat_r;
  assign bus.busy         = (state_r != IDLE);

endmodule

// File: tb/tb_helppll_fdiff_mc.sv
// Randomized bench for helppll_fdiff_mc against a gate-level-of-abstraction
// reference: sample schedule, per-gate count deltas and saturated error values.
module tb_helppll_fdiff_mc;
  localparam int NCH  = 2;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int MW   = 4;
  localparam longint GMIN = 3 * NCH + 2;

  typedef struct {
    longint      due;
    int          ch;
    logic [31:0] val;
    bit          sat;
  } exp_t;

  logic clk = 1'b0;
  logic areset;
  helppll_fdiff_mc_if #(.NCH(NCH), .DWIDTH(DW), .CWIDTH(CW), .MWIDTH(MW)) bus ();

  helppll_fdiff_mc #(.NCH(NCH), .DWIDTH(DW), .CWIDTH(CW), .MWIDTH(MW)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  longint      cyc   = 0;
  exp_t        q[$];
  bit          have_prev = 1'b0;
  bit          en_m      = 1'b0;
  longint      next_samp = 0;
  int          cnt [NCH];
  int          prv [NCH];
  int          dlt [NCH];
  bit          rnd_d = 1'b0;
  bit          rnd_m = 1'b0;
  logic [31:0] last_fd  [NCH];
  bit          last_sat [NCH];
  int          n_stb = 0;
  bit          seen0 = 1'b0;
  int          n0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference error: hmul*delta - rmul*gate, clipped to signed 32 bits
  function automatic void ref_calc(input longint d, input longint hm, input longint rm,
                                   input longint g, output logic [31:0] v, output bit s);
    longint diff;
    longint hi;
    longint lo;
    hi   = (longint'(1) <<< 31) - 1;
    lo   = -(longint'(1) <<< 31);
    diff = hm * d - rm * g;
    if (diff > hi) begin
      v = 32'h7FFF_FFFF; s = 1'b1;
    end else if (diff < lo) begin
      v = 32'h8000_0000; s = 1'b1;
    end else begin
      v = diff[31:0];    s = 1'b0;
    end
  endfunction

  task automatic apply_cnt();
    logic [NCH*CW-1:0] v;
    logic [CW-1:0]     b;
    for (int k = 0; k < NCH; k++) begin
      b = cnt[k][CW-1:0];
      v[k*CW +: CW] = b ^ (b >> 1);
    end
    bus.cnt_gray = v;
  endtask

  // Model one clock cycle with the inputs currently driven, then advance
  task automatic tick();
    longint g;
    bit     upd;
    exp_t   e;
    upd = 1'b0;
    g = (longint'(bus.gate_len) < GMIN) ? GMIN : longint'(bus.gate_len);
    if (!bus.enable || areset) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      have_prev = 1'b0;
      en_m      = 1'b0;
    end else begin
      if (!en_m) begin
        en_m      = 1'b1;
        next_samp = cyc + g - 1;
      end
      if (cyc == next_samp) begin
        if (have_prev) begin
          for (int k = 0; k < NCH; k++) begin
            e.due = cyc + 4 + 3 * k;
            e.ch  = k;
            ref_calc(longint'((cnt[k] - prv[k]) & 32'h0000_FFFF), longint'(bus.hmul),
                     longint'(bus.rmul), g, e.val, e.sat);
            q.push_back(e);
          end
        end
        for (int k = 0; k < NCH; k++) prv[k] = cnt[k];
        have_prev = 1'b1;
        next_samp = cyc + g;
        upd       = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (upd) begin
      for (int k = 0; k < NCH; k++) begin
        cnt[k] = (cnt[k] + (rnd_d ? int'($urandom_range(0, 65535)) : dlt[k])) & 32'h0000_FFFF;
      end
      apply_cnt();
      if (rnd_m) begin
        bus.hmul = 4'($urandom_range(0, 15));
        bus.rmul = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic stop_run();
    bus.enable = 1'b0;
    ticks(2);
  endtask

  task automatic wait_seen0(input string tag);
    seen0 = 1'b0;
    for (int i = 0; i < 400 && !seen0; i++) tick();
    chk(tag, longint'(seen0), 1);
  endtask

  // Scoreboard: every strobe must match the oldest expected result, on time
  always @(negedge clk) begin
    exp_t e;
    if (!areset) begin
      if (bus.stb_freqdiff) begin
        n_stb++;
        last_fd[bus.freqdiff_ch]  = bus.freqdiff;
        last_sat[bus.freqdiff_ch] = bus.sat;
        if (bus.freqdiff_ch == 1'b0) seen0 = 1'b1;
        if (q.size() == 0) begin
          chk("spurious_stb", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stb_cycle", cyc, e.due);
          chk("freqdiff", longint'(bus.freqdiff), longint'(e.val));
          chk("freqdiff_ch", longint'(bus.freqdiff_ch), longint'(e.ch));
          chk("sat", longint'(bus.sat), longint'(e.sat));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_stb", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset       = 1'b1;
    bus.enable   = 1'b0;
    bus.gate_len = 32'd100;
    bus.hmul     = 4'd1;
    bus.rmul     = 4'd1;
    for (int k = 0; k < NCH; k++) begin
      cnt[k] = 0; dlt[k] = 0; last_fd[k] = 32'h0; last_sat[k] = 1'b0;
    end
    apply_cnt();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_freqdiff", longint'(bus.freqdiff), 0);
    chk("rst_ch", longint'(bus.freqdiff_ch), 0);
    chk("rst_stb", longint'(bus.stb_freqdiff), 0);
    chk("rst_sat", longint'(bus.sat), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    areset = 1'b0;
    ticks(2);

    // Basic: ch0 on frequency, ch1 three counts fast
    dlt[0] = 100; dlt[1] = 103;
    bus.enable = 1'b1;
    ticks(410);
    chk("basic_ch0", longint'(last_fd[0]), 0);
    chk("basic_ch1", longint'(last_fd[1]), 3);
    chk("basic_sat", longint'(last_sat[1]), 0);
    stop_run();

    // Counter wrap 0xFFF0 -> 0x0054
    cnt[0] = 32'hFFF0; dlt[0] = 100; dlt[1] = 100;
    apply_cnt();
    ticks(1);
    bus.enable = 1'b1;
    ticks(210);
    chk("wrap_ch0", longint'(last_fd[0]), 0);
    stop_run();

    // Ratio hmul=2, rmul=1, gate 1000: 500 -> 0, 501 -> +2
    bus.hmul = 4'd2; bus.rmul = 4'd1; bus.gate_len = 32'd1000;
    dlt[0] = 500; dlt[1] = 500;
    ticks(1);
    bus.enable = 1'b1;
    ticks(1500);
    dlt[0] = 501; dlt[1] = 501;
    ticks(520);
    chk("ratio_500", longint'(last_fd[0]), 0);
    ticks(1000);
    chk("ratio_501", longint'(last_fd[0]), 2);
    stop_run();

    // Negative saturation: huge gate latched on the measuring sample
    bus.hmul = 4'd1; bus.rmul = 4'd15; bus.gate_len = 32'd50;
    dlt[0] = 50; dlt[1] = 50;
    ticks(1);
    bus.enable = 1'b1;
    ticks(60);
    bus.gate_len = 32'h7FFF_FFF0;
    ticks(60);
    chk("sat_ch0_val", longint'(last_fd[0]), longint'(32'h8000_0000));
    chk("sat_ch1_val", longint'(last_fd[1]), longint'(32'h8000_0000));
    chk("sat_ch0_flag", longint'(last_sat[0]), 1);
    chk("sat_ch1_flag", longint'(last_sat[1]), 1);
    stop_run();

    // Clamped gate (gate_len=3 -> 8 cycles), 20 measured gates
    bus.gate_len = 32'd3; bus.hmul = 4'd1; bus.rmul = 4'd1;
    rnd_d = 1'b1;
    ticks(1);
    n0 = n_stb;
    bus.enable = 1'b1;
    ticks(175);
    bus.enable = 1'b0;
    ticks(2);
    chk("clamp_stb_count", longint'(n_stb - n0), 40);

    // Enable dropped right after the ch0 strobe, re-enabled 5 cycles later
    bus.gate_len = 32'd20;
    ticks(1);
    bus.enable = 1'b1;
    wait_seen0("abort_wait_ch0");
    bus.enable = 1'b0;
    ticks(5);
    bus.enable = 1'b1;
    n0 = n_stb;
    ticks(43);
    chk("abort_no_early_stb", longint'(n_stb - n0), 0);
    ticks(10);
    chk("abort_resume_stb", longint'(n_stb - n0), 2);

    // areset pulse in the middle of a burst
    wait_seen0("rst_wait_ch0");
    chk("midrst_busy_pre", longint'(bus.busy), 1);
    areset = 1'b1;
    q.delete();
    have_prev = 1'b0;
    en_m      = 1'b0;
    #2;
    chk("midrst_freqdiff", longint'(bus.freqdiff), 0);
    chk("midrst_ch", longint'(bus.freqdiff_ch), 0);
    chk("midrst_stb", longint'(bus.stb_freqdiff), 0);
    chk("midrst_sat", longint'(bus.sat), 0);
    chk("midrst_busy", longint'(bus.busy), 0);
    bus.enable = 1'b0;
    ticks(2);
    areset = 1'b0;
    ticks(2);

    // Random gates, multipliers, deltas and enable windows
    rnd_m = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bus.enable   = 1'b0;
      bus.gate_len = 32'($urandom_range(2, 40));
      bus.hmul     = 4'($urandom_range(0, 15));
      bus.rmul     = 4'($urandom_range(0, 15));
      ticks(2);
      bus.enable = 1'b1;
      ticks(int'($urandom_range(60, 300)));
    end
    stop_run();
    ticks(10);
    chk("queue_drained", longint'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
